z3_slave_engine: RTL and testbench
==================================

Z3_SLAVE_ENGINE -- requirements
Module: z3_slave_engine

Interface
REQ-001 SHALL have parameter NUM_REGIONS, default 5, number of decoded slave regions (1..8).
REQ-002 SHALL have parameter ADDR_W, default 24, width of the board-local address compared against regions.
REQ-003 SHALL have parameter REGION_BASE, default {24'h8C0000,24'h880000,24'h840000,24'h800000,24'h000000}, packed inclusive lower bounds, region 0 in LSBs.
REQ-004 SHALL have parameter REGION_LIMIT, default {24'h8F0000,24'h8C0000,24'h880000,24'h840000,24'h800000}, packed exclusive upper bounds.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 255, DATA-phase wait limit; 0 disables the timeout.
REQ-006 SHALL have port CLK  input  1  single clock for all logic.
REQ-007 SHALL have port RESET  input  1  reset, synchronous to CLK and active-high.
REQ-008 SHALL have port FCS_n  input  1  Zorro frame strobe, already synchronised to CLK.
REQ-009 SHALL have port BASE_MATCH  input  1  board address match latched at cycle start.
REQ-010 SHALL have port VALIDSPACE  input  1  FC[1]^FC[0].
REQ-011 SHALL have port READ  input  1  Zorro READ.
REQ-012 SHALL have port DS_n  input  4  Zorro data strobes.
REQ-013 SHALL have port ADDR  input  ADDR_W  board-local address.
REQ-014 SHALL have port DEV_ACK  input  NUM_REGIONS  per-region completion, level.
REQ-015 SHALL have port DEV_SEL  output  NUM_REGIONS  one-hot region select.
REQ-016 SHALL have port DTACK  output  1  active-high DTACK request (top-level drives open-drain).
REQ-017 SHALL have port BERR  output  1  active-high bus-error request.
REQ-018 SHALL have port BUSY  output  1  high whenever state is not IDLE.
REQ-019 SHALL have port ERR_COUNT  output  8  saturating timeout counter.

Function
REQ-020 SHALL implement states IDLE, START, DATA, END, ERROR; all outputs registered.
REQ-021 IDLE: FCS_n=0 & BASE_MATCH & VALIDSPACE & ADDR in some region -> START next cycle, latching the lowest-indexed matching region (base<=ADDR<limit).
REQ-022 IDLE: no region hit -> remain IDLE, no output asserted.
REQ-023 START: READ=1 or any DS_n bit low -> DATA; otherwise hold.
REQ-024 DATA: DEV_SEL[latched] high for every DATA cycle, all other bits low.
REQ-025 DATA: DEV_ACK[latched]=1 -> END; acks from other regions ignored.
REQ-026 DATA: wait counter clears on entry, increments each cycle; at TIMEOUT_CYCLES without ack -> ERROR; ack on that same cycle wins (-> END).
REQ-027 END: DTACK=1 until FCS_n=1; ERROR: BERR=1 until FCS_n=1.
REQ-028 FCS_n=1 in START, DATA, END or ERROR -> IDLE next cycle, DEV_SEL/DTACK/BERR low that cycle.
REQ-029 DEV_ACK to DTACK latency SHALL be one cycle (ack sampled at edge n, DTACK high after edge n+1).
REQ-030 ERR_COUNT SHALL increment on each DATA->ERROR transition and saturate at 255.
REQ-031 Wait counter width SHALL be clog2(TIMEOUT_CYCLES+1), minimum 1.

Reset
REQ-032 RESET=1 at a CLK edge SHALL force IDLE, DEV_SEL=0, DTACK=0, BERR=0, BUSY=0, ERR_COUNT=0, wait counter=0, overriding any in-progress cycle.

Structure
REQ-033 Package z3_pkg SHALL hold the state enum and default region base/limit constants.
REQ-034 Region decoding SHALL live in sub-module z3_region_decode (ADDR -> hit flag + index, combinational priority).

Verification
REQ-035 Read ADDR=0x800010, READ=1, DEV_ACK[1] at DATA cycle 3 -> DEV_SEL=5'b00010, DTACK high one cycle later until FCS_n rises.
REQ-036 Write ADDR=0x000100, READ=0, DS_n=4'b1110 two cycles after FCS_n -> START holds until DS_n low, then DEV_SEL[0].
REQ-037 ADDR=0x8F8000 -> stays IDLE, BUSY=0, no DTACK/BERR.
REQ-038 TIMEOUT_CYCLES=4, no ack -> ERROR after 4 DATA cycles, BERR=1, ERR_COUNT 0->1; 256 timeouts -> ERR_COUNT=255.
REQ-039 DEV_ACK on exact timeout cycle -> END, BERR never asserts; FCS_n=1 mid-DATA -> IDLE next cycle.
REQ-040 RESET=1 during END -> DTACK=0 next cycle, state IDLE.

Source files
------------

// File: rtl/z3_pkg.sv
// Shared types and default region map for the Zorro III slave engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package z3_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_END,
        ST_ERROR
    } state_t;

    // Region index width covers the maximum of 8 decoded regions.
    localparam int Z3_IDX_W = 3;

    localparam int Z3_DEF_REGIONS = 5;
    localparam int Z3_DEF_ADDR_W  = 24;

    // Inclusive lower bounds, region 0 in the LSBs.
    localparam logic [Z3_DEF_REGIONS*Z3_DEF_ADDR_W-1:0] Z3_DEF_BASE =
        {24'h8C0000, 24'h880000, 24'h840000, 24'h800000, 24'h000000};

    // Exclusive upper bounds, region 0 in the LSBs.
    localparam logic [Z3_DEF_REGIONS*Z3_DEF_ADDR_W-1:0] Z3_DEF_LIMIT =
        {24'h8F0000, 24'h8C0000, 24'h880000, 24'h840000, 24'h800000};

endpackage

// File: rtl/z3_region_decode.sv
// Maps a board-local address to the lowest-indexed region with base <= addr < limit.
// Latency: purely combinational.
// Backpressure: none; result is valid whenever addr_i is stable.
module z3_region_decode
    import z3_pkg::*;
#(
    parameter int NUM_REGIONS = Z3_DEF_REGIONS,
    parameter int ADDR_W      = Z3_DEF_ADDR_W,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE  = Z3_DEF_BASE,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LIMIT = Z3_DEF_LIMIT
) (
    input  logic [ADDR_W-1:0]   addr_i,
    output logic                hit_o,
    output logic [Z3_IDX_W-1:0] idx_o
);

    // Scan from the top down so the lowest matching index is the last one written.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if ((addr_i >= REGION_BASE[i*ADDR_W +: ADDR_W]) &&
                (addr_i <  REGION_LIMIT[i*ADDR_W +: ADDR_W])) begin
                hit_o = 1'b1;
                idx_o = Z3_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/z3_slave_engine.sv
// Zorro III slave cycle engine: decodes a region, selects the device, answers with DTACK or BERR.
// Latency: START one cycle after FCS_n; DTACK one cycle after the ack is taken into END.
// Backpressure: device stalls DATA by holding DEV_ACK low, bounded by TIMEOUT_CYCLES.
module z3_slave_engine
    import z3_pkg::*;
#(
    parameter int NUM_REGIONS    = Z3_DEF_REGIONS,
    parameter int ADDR_W         = Z3_DEF_ADDR_W,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE  = Z3_DEF_BASE,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LIMIT = Z3_DEF_LIMIT,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   FCS_n,
    input  logic                   BASE_MATCH,
    input  logic                   VALIDSPACE,
    input  logic                   READ,
    input  logic [3:0]             DS_n,
    input  logic [ADDR_W-1:0]      ADDR,
    input  logic [NUM_REGIONS-1:0] DEV_ACK,
    output logic [NUM_REGIONS-1:0] DEV_SEL,
    output logic                   DTACK,
    output logic                   BERR,
    output logic                   BUSY,
    output logic [7:0]             ERR_COUNT
);

    localparam int WAIT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    state_t                state_q, state_d;
    logic [Z3_IDX_W-1:0]   sel_q, sel_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [7:0]            err_cnt_q, err_cnt_d;
    logic [NUM_REGIONS-1:0] dev_sel_q, dev_sel_d;
    logic                  dtack_q, dtack_d;
    logic                  berr_q, berr_d;
    logic                  busy_q, busy_d;

    logic                  hit;
    logic [Z3_IDX_W-1:0]   hit_idx;
    logic                  strobe;
    logic                  timeout;

    z3_region_decode #(
        .NUM_REGIONS (NUM_REGIONS),
        .ADDR_W      (ADDR_W),
        .REGION_BASE (REGION_BASE),
        .REGION_LIMIT(REGION_LIMIT)
    ) u_decode (
        .addr_i(ADDR),
        .hit_o (hit),
        .idx_o (hit_idx)
    );

    assign strobe = READ || (DS_n != 4'hF);

    // The Nth DATA cycle without an ack is the last one; counter holds N-1 during it.
    assign timeout = (TIMEOUT_CYCLES != 0) &&
                     (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));

    // Next-state logic; a rising FCS_n always wins and ends the cycle.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        wait_d    = wait_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (!FCS_n && BASE_MATCH && VALIDSPACE && hit) begin
                    state_d = ST_START;
                    sel_d   = hit_idx;
                end
            end
            ST_START: begin
                if (FCS_n) begin
                    state_d = ST_IDLE;
                end else if (strobe) begin
                    state_d = ST_DATA;
                    wait_d  = '0;
                end
            end
            ST_DATA: begin
                if (FCS_n) begin
                    state_d = ST_IDLE;
                end else if (DEV_ACK[sel_q]) begin
                    state_d = ST_END;
                end else if (timeout) begin
                    state_d = ST_ERROR;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_END, ST_ERROR: begin
                if (FCS_n) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: select tracks DATA exactly, DTACK/BERR trail END/ERROR entry by one cycle.
    always_comb begin
        dev_sel_d = '0;
        if (state_d == ST_DATA) begin
            dev_sel_d = NUM_REGIONS'(1) << sel_d;
        end
        dtack_d = (state_q == ST_END)   && !FCS_n;
        berr_d  = (state_q == ST_ERROR) && !FCS_n;
        busy_d  = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset overrides any cycle in progress.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            wait_q    <= '0;
            err_cnt_q <= '0;
            dev_sel_q <= '0;
            dtack_q   <= 1'b0;
            berr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            wait_q    <= wait_d;
            err_cnt_q <= err_cnt_d;
            dev_sel_q <= dev_sel_d;
            dtack_q   <= dtack_d;
            berr_q    <= berr_d;
            busy_q    <= busy_d;
        end
    end

    assign DEV_SEL   = dev_sel_q;
    assign DTACK     = dtack_q;
    assign BERR      = berr_q;
    assign BUSY      = busy_q;
    assign ERR_COUNT = err_cnt_q;

endmodule

// File: tb/tb_z3_slave_engine.sv
// Bench for z3_slave_engine: directed Zorro cycles plus randomized transactions.
// Expected behaviour comes from a transaction-level view of region map, timeout and strobe rules.
// Inputs change #1 after the rising edge, outputs are sampled at that same point.
module tb_z3_slave_engine;

    localparam int T = 4;

    localparam int RB [5] = '{32'h000000, 32'h800000, 32'h840000, 32'h880000, 32'h8C0000};
    localparam int RL [5] = '{32'h800000, 32'h840000, 32'h880000, 32'h8C0000, 32'h8F0000};

    logic        CLK = 1'b0;
    logic        RESET;
    logic        FCS_n;
    logic        BASE_MATCH;
    logic        VALIDSPACE;
    logic        READ;
    logic [3:0]  DS_n;
    logic [23:0] ADDR;
    logic [4:0]  DEV_ACK;
    logic [4:0]  DEV_SEL;
    logic        DTACK;
    logic        BERR;
    logic        BUSY;
    logic [7:0]  ERR_COUNT;

    int tests = 0;
    int fails = 0;
    int err_exp = 0;

    z3_slave_engine #(
        .NUM_REGIONS   (5),
        .ADDR_W        (24),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .FCS_n     (FCS_n),
        .BASE_MATCH(BASE_MATCH),
        .VALIDSPACE(VALIDSPACE),
        .READ      (READ),
        .DS_n      (DS_n),
        .ADDR      (ADDR),
        .DEV_ACK   (DEV_ACK),
        .DEV_SEL   (DEV_SEL),
        .DTACK     (DTACK),
        .BERR      (BERR),
        .BUSY      (BUSY),
        .ERR_COUNT (ERR_COUNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Lowest-indexed region containing a, or -1.
    function automatic int region_of(input logic [23:0] a);
        int r;
        bit found;
        r = -1;
        found = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (!found && int'(a) >= RB[i] && int'(a) < RL[i]) begin
                r = i;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [4:0] sel, input logic dt,
                           input logic be, input logic bu);
        chk({tag, ".sel"},   32'(DEV_SEL), 32'(sel));
        chk({tag, ".dtack"}, 32'(DTACK),   32'(dt));
        chk({tag, ".berr"},  32'(BERR),    32'(be));
        chk({tag, ".busy"},  32'(BUSY),    32'(bu));
    endtask

    task automatic release_bus();
        FCS_n   = 1'b1;
        DS_n    = 4'hF;
        DEV_ACK = 5'd0;
        READ    = 1'b0;
        tick();
        chk_out("release", 5'd0, 1'b0, 1'b0, 1'b0);
        chk("release.errcnt", 32'(ERR_COUNT), 32'(err_exp));
        tick();
    endtask

    // One Zorro cycle. ack_at / abort_at are 1-based DATA cycle numbers (0 = never).
    task automatic txn(input logic [23:0] addr, input logic rd, input logic bm, input logic vs,
                       input int sd, input logic [3:0] ds_pat, input int ack_at,
                       input int abort_at, input int hold, input bit rst_end);
        int         rg;
        bit         hit;
        bit         is_end;
        logic [4:0] sel;
        string      t;
        rg  = region_of(addr);
        hit = bm && vs && (rg >= 0);
        sel = (rg >= 0) ? 5'(1 << rg) : 5'd0;

        ADDR = addr; READ = rd; BASE_MATCH = bm; VALIDSPACE = vs;
        DS_n = 4'hF; DEV_ACK = 5'd0; FCS_n = 1'b0;
        tick();

        if (!hit) begin
            for (int i = 0; i < 3; i++) begin
                chk_out("miss", 5'd0, 1'b0, 1'b0, 1'b0);
                DS_n    = ds_pat;
                DEV_ACK = 5'($urandom);
                tick();
            end
            chk_out("miss_last", 5'd0, 1'b0, 1'b0, 1'b0);
            release_bus();
            return;
        end

        chk_out("start", 5'd0, 1'b0, 1'b0, 1'b1);
        if (!rd) begin
            for (int i = 0; i < sd; i++) begin
                tick();
                chk_out("start_hold", 5'd0, 1'b0, 1'b0, 1'b1);
            end
            DS_n = ds_pat;
        end
        tick();

        is_end = 1'b0;
        for (int k = 1; k <= T; k++) begin
            chk_out("data", sel, 1'b0, 1'b0, 1'b1);
            DEV_ACK = 5'($urandom) & ~sel;
            if (k == ack_at) DEV_ACK = DEV_ACK | sel;
            if (k == abort_at) FCS_n = 1'b1;
            tick();
            if (k == abort_at) begin
                chk_out("abort", 5'd0, 1'b0, 1'b0, 1'b0);
                release_bus();
                return;
            end
            if (k == ack_at) begin
                is_end = 1'b1;
                break;
            end
        end

        if (!is_end) err_exp = (err_exp >= 255) ? 255 : err_exp + 1;
        DEV_ACK = is_end ? sel : 5'd0;
        chk_out("end_first", 5'd0, 1'b0, 1'b0, 1'b1);
        chk("end.errcnt", 32'(ERR_COUNT), 32'(err_exp));
        if (is_end) t = "dtack_hold"; else t = "berr_hold";
        for (int i = 0; i < hold; i++) begin
            tick();
            chk_out(t, 5'd0, is_end, !is_end, 1'b1);
        end

        if (rst_end) begin
            RESET = 1'b1;
            tick();
            err_exp = 0;
            chk_out("rst_end", 5'd0, 1'b0, 1'b0, 1'b0);
            chk("rst_end.errcnt", 32'(ERR_COUNT), 32'(err_exp));
            RESET = 1'b0;
        end
        release_bus();
    endtask

    initial begin
        logic [23:0] a;
        int          j;
        int          pick;

        RESET = 1'b1; FCS_n = 1'b1; BASE_MATCH = 1'b0; VALIDSPACE = 1'b0;
        READ = 1'b0; DS_n = 4'hF; ADDR = 24'd0; DEV_ACK = 5'd0;
        tick();
        tick();
        chk_out("reset", 5'd0, 1'b0, 1'b0, 1'b0);
        chk("reset.errcnt", 32'(ERR_COUNT), 32'd0);
        RESET = 1'b0;
        tick();

        // Read into region 1, ack in DATA cycle 3.
        txn(24'h800010, 1'b1, 1'b1, 1'b1, 0, 4'hF, 3, 0, 2, 1'b0);
        // Write into region 0, byte strobe two cycles late.
        txn(24'h000100, 1'b0, 1'b1, 1'b1, 2, 4'b1110, 2, 0, 2, 1'b0);
        // Address above every region.
        txn(24'h8F8000, 1'b1, 1'b1, 1'b1, 0, 4'hF, 1, 0, 1, 1'b0);
        // No ack: timeout to ERROR, first error count.
        txn(24'h840000, 1'b1, 1'b1, 1'b1, 0, 4'hF, 0, 0, 2, 1'b0);
        chk("err_first", 32'(ERR_COUNT), 32'd1);
        // Ack on the exact timeout cycle wins.
        txn(24'h8EFFFF, 1'b0, 1'b1, 1'b1, 0, 4'b0000, T, 0, 2, 1'b0);
        // Frame strobe released in the middle of DATA.
        txn(24'h880000, 1'b1, 1'b1, 1'b1, 0, 4'hF, 0, 2, 1, 1'b0);
        // Qualifiers low with an in-range address.
        txn(24'h000000, 1'b1, 1'b0, 1'b1, 0, 4'hF, 1, 0, 1, 1'b0);
        txn(24'h7FFFFF, 1'b1, 1'b1, 1'b0, 0, 4'hF, 1, 0, 1, 1'b0);

        for (int n = 0; n < 150; n++) begin
            pick = int'($urandom_range(0, 3));
            j    = int'($urandom_range(0, 4));
            case (pick)
                0: a = 24'($urandom);
                1: a = 24'(RB[j] + int'($urandom_range(0, 32'(RL[j] - RB[j] - 1))));
                2: begin
                    case ($urandom_range(0, 2))
                        0: a = 24'(RB[j]);
                        1: a = 24'(RL[j] - 1);
                        default: a = 24'(RL[j]);
                    endcase
                end
                default: a = 24'(32'h8F0000 + $urandom_range(0, 32'h70FFFF));
            endcase
            txn(a, 1'($urandom), ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0),
                int'($urandom_range(0, 3)), 4'($urandom_range(0, 14)),
                int'($urandom_range(0, 6)),
                ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, T)) : 0,
                int'($urandom_range(1, 3)), 1'b0);
        end

        for (int n = 0; n < 256; n++) begin
            txn(24'h850000, 1'b1, 1'b1, 1'b1, 0, 4'hF, 0, 0, 1, 1'b0);
        end
        chk("err_saturated", 32'(ERR_COUNT), 32'd255);

        // Reset while DTACK is being driven.
        txn(24'h8C0004, 1'b1, 1'b1, 1'b1, 0, 4'hF, 1, 0, 1, 1'b1);
        txn(24'h800020, 1'b1, 1'b1, 1'b1, 0, 4'hF, 2, 0, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
